// File: rtl/mod_arith_pipe_if.sv
// Handshake bundle for mod_arith_pipe: operand input channel, result output channel
// and status. The master side drives operands and consumes results.
interface mod_arith_pipe_if #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned TAG_W = 8,
  parameter int unsigned CNT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_res;
  logic [TAG_W-1:0] out_tag;
  logic             range_err;
  logic [CNT_W-1:0] op_count;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_res, out_tag, range_err, op_count
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_res, out_tag, range_err, op_count
  );
endinterface

// File: rtl/mod_arith_pipe.sv
// Four-stage elastic modular MUL/ADD/SUB/PASS unit with Barrett reduction, sideband tag,
// sticky operand range error and a saturating completion counter.
module mod_arith_pipe #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned Q     = 3329,
  parameter int unsigned TAG_W = 8,
  parameter int unsigned CNT_W = 32
) (
  input logic               clk,
  input logic               rst,
  mod_arith_pipe_if.slave   bus
);
  localparam int unsigned      K     = 2 * WIDTH;
  localparam int unsigned      RW    = WIDTH + 2;
  localparam int unsigned      PW    = 2 * K + 1;
  localparam logic [63:0]      MFull = (64'd1 << K) / 64'(Q);
  localparam logic [K:0]       M     = MFull[K:0];
  localparam logic [WIDTH-1:0] QW    = WIDTH'(Q);

  typedef enum logic [1:0] {OpMul = 2'b00, OpAdd = 2'b01, OpSub = 2'b10, OpPass = 2'b11} op_e;

  logic             s0_v_q, s1_v_q, s2_v_q, s3_v_q;
  logic             s0_ld, s1_ld, s2_ld, s3_ld, in_fire;
  logic [1:0]       s0_op_q;
  logic [WIDTH-1:0] s0_a_q, s0_b_q;
  logic [TAG_W-1:0] s0_tag_q, s1_tag_q, s2_tag_q, s3_tag_q;
  logic [K-1:0]     s1_raw_q, raw_d;
  logic [RW-1:0]    s2_r_q, r_d, r1, r2;
  logic [WIDTH-1:0] s3_res_q;
  logic [PW-1:0]    prod, qq;
  logic [K:0]       qhat;
  logic             range_err_q, range_err_d, a_bad, b_bad;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic             unused_prod_lo;

  // A stage loads when empty or when its occupant leaves this cycle, so bubbles collapse.
  always_comb begin
    s3_ld   = ~s3_v_q | bus.out_ready;
    s2_ld   = ~s2_v_q | s3_ld;
    s1_ld   = ~s1_v_q | s2_ld;
    s0_ld   = ~s0_v_q | s1_ld;
    in_fire = bus.in_valid & s0_ld;
  end

  always_comb begin
    raw_d = '0;
    unique case (op_e'(s0_op_q))
      OpMul:  raw_d = K'(s0_a_q) * K'(s0_b_q);
      OpAdd:  raw_d = K'(s0_a_q) + K'(s0_b_q);
      OpSub:  raw_d = K'(s0_a_q) + K'(QW) - K'(s0_b_q);
      OpPass: raw_d = K'(s0_a_q);
    endcase
  end

  // Barrett: qhat underestimates raw/Q by at most 2, so r lands in [0, 3Q).
  always_comb begin
    prod = PW'(s1_raw_q) * PW'(M);
    qhat = prod[PW-1:K];
    qq   = PW'(qhat) * PW'(QW);
    r_d  = RW'(s1_raw_q) - RW'(qq);
  end
  assign unused_prod_lo = ^prod[K-1:0];

  always_comb begin
    r1 = (s2_r_q >= RW'(QW)) ? s2_r_q - RW'(QW) : s2_r_q;
    r2 = (r1 >= RW'(QW)) ? r1 - RW'(QW) : r1;
  end

  always_comb begin
    a_bad       = bus.in_a >= QW;
    b_bad       = (bus.in_op != OpPass) && (bus.in_b >= QW);
    range_err_d = range_err_q | (in_fire & (a_bad | b_bad));
    op_count_d  = op_count_q;
    if (s3_v_q && bus.out_ready && !(&op_count_q)) begin
      op_count_d = op_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s0_v_q      <= 1'b0;
      s1_v_q      <= 1'b0;
      s2_v_q      <= 1'b0;
      s3_v_q      <= 1'b0;
      s0_op_q     <= '0;
      s0_a_q      <= '0;
      s0_b_q      <= '0;
      s0_tag_q    <= '0;
      s1_raw_q    <= '0;
      s1_tag_q    <= '0;
      s2_r_q      <= '0;
      s2_tag_q    <= '0;
      s3_res_q    <= '0;
      s3_tag_q    <= '0;
      range_err_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      range_err_q <= range_err_d;
      op_count_q  <= op_count_d;
      if (s0_ld) s0_v_q <= bus.in_valid;
      if (s1_ld) s1_v_q <= s0_v_q;
      if (s2_ld) s2_v_q <= s1_v_q;
      if (s3_ld) s3_v_q <= s2_v_q;
      if (in_fire) begin
        s0_op_q  <= bus.in_op;
        s0_a_q   <= bus.in_a;
        s0_b_q   <= bus.in_b;
        s0_tag_q <= bus.in_tag;
      end
      if (s1_ld && s0_v_q) begin
        s1_raw_q <= raw_d;
        s1_tag_q <= s0_tag_q;
      end
      if (s2_ld && s1_v_q) begin
        s2_r_q   <= r_d;
        s2_tag_q <= s1_tag_q;
      end
      // Output registers only change on a load, keeping results stable under backpressure.
      if (s3_ld && s2_v_q) begin
        s3_res_q <= r2[WIDTH-1:0];
        s3_tag_q <= s2_tag_q;
      end
    end
  end

  assign bus.in_ready  = s0_ld;
  assign bus.out_valid = s3_v_q;
  assign bus.out_res   = s3_res_q;
  assign bus.out_tag   = s3_tag_q;
  assign bus.range_err = range_err_q;
  assign bus.op_count  = op_count_q;
endmodule

// File: tb/tb_mod_arith_pipe.sv
// Self-checking bench for mod_arith_pipe: directed scenarios plus a randomized stream,
// scored against a plain-arithmetic reference and an in-order expectation queue.
module tb_mod_arith_pipe;
  localparam int unsigned WIDTH = 12;
  localparam int unsigned Q     = 3329;
  localparam int unsigned TAG_W = 8;
  localparam int unsigned CNT_W = 32;

  typedef struct {
    int unsigned res;
    int unsigned tag;
    bit          dc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mod_arith_pipe_if #(.WIDTH(WIDTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) bus ();

  mod_arith_pipe #(.WIDTH(WIDTH), .Q(Q), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  int unsigned exp_count = 0;
  bit          exp_range = 0;
  bit          stall_prev = 0;
  logic [WIDTH-1:0] held_res;
  logic [TAG_W-1:0] held_tag;
  int          accepted = 0;

  function automatic int unsigned ref_op(int unsigned op, int unsigned a, int unsigned b);
    int sd;
    case (op)
      0: return (a * b) % Q;
      1: return (a + b) % Q;
      2: begin
        sd = int'(a) - int'(b);
        return int'(((sd % int'(Q)) + int'(Q)) % int'(Q));
      end
      default: return a % Q;
    endcase
  endfunction

  task automatic chk(string name, logic [63:0] obs, logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", name, obs, expv);
    end
  endtask

  task automatic drive(bit v, int unsigned op, int unsigned a, int unsigned b, int unsigned tag);
    bus.in_valid = v;
    bus.in_op    = 2'(op);
    bus.in_a     = WIDTH'(a);
    bus.in_b     = WIDTH'(b);
    bus.in_tag   = TAG_W'(tag);
  endtask

  task automatic drive_rand(bit v);
    drive(v, $urandom_range(0, 3), $urandom_range(0, Q - 1), $urandom_range(0, Q - 1),
          $urandom_range(0, 255));
  endtask

  // One clock: score the handshakes visible now, then advance to the next falling edge.
  task automatic tick();
    exp_t e;
    int unsigned a, b, op;
    #1;
    if (rst === 1'b0) begin
      exp_q.delete();
      exp_count  = 0;
      exp_range  = 0;
      stall_prev = 0;
    end else begin
      if (stall_prev && bus.out_valid === 1'b1) begin
        chk("hold_res", 64'(bus.out_res), 64'(held_res));
        chk("hold_tag", 64'(bus.out_tag), 64'(held_tag));
      end
      if (bus.out_valid === 1'b1 && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 64'(bus.out_valid), 64'(0));
        end else begin
          e = exp_q.pop_front();
          if (!e.dc) chk("res", 64'(bus.out_res), 64'(e.res));
          chk("tag", 64'(bus.out_tag), 64'(e.tag));
          exp_count++;
        end
      end
      stall_prev = (bus.out_valid === 1'b1) && !bus.out_ready;
      held_res   = bus.out_res;
      held_tag   = bus.out_tag;
      if (bus.in_valid && bus.in_ready === 1'b1) begin
        op = bus.in_op;
        a  = bus.in_a;
        b  = bus.in_b;
        e.dc  = (a >= Q) || (op != 3 && b >= Q);
        e.res = e.dc ? 0 : ref_op(op, a, b);
        e.tag = bus.in_tag;
        if (e.dc) exp_range = 1;
        exp_q.push_back(e);
        accepted++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic drain();
    drive(0, 0, 0, 0, 0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic lat_check(int unsigned op, int unsigned a, int unsigned b, int unsigned tag,
                           int unsigned expv);
    drive(1, op, a, b, tag);
    tick();
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("lat_early", 64'(bus.out_valid), 64'(0));
      tick();
    end
    chk("lat_valid", 64'(bus.out_valid), 64'(1));
    chk("lat_res", 64'(bus.out_res), 64'(expv));
    chk("lat_tag", 64'(bus.out_tag), 64'(tag));
    tick();
  endtask

  initial begin
    bus.out_ready = 1'b1;
    drive(1, 0, 100, 200, 1);
    @(negedge clk);

    // Reset held with traffic offered
    for (int i = 0; i < 3; i++) begin
      drive_rand(1);
      tick();
    end
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_op_count", 64'(bus.op_count), 64'(0));
    chk("rst_range_err", 64'(bus.range_err), 64'(0));
    chk("rst_out_res", 64'(bus.out_res), 64'(0));
    chk("rst_out_tag", 64'(bus.out_tag), 64'(0));
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
    for (int i = 0; i < 6; i++) tick();
    chk("rst_no_output", 64'(bus.out_valid), 64'(0));

    // Multiplication and latency
    lat_check(0, 1234, 2345, 8'h5A, 829);
    lat_check(0, 3328, 3328, 8'h11, 1);

    // Back-to-back mixed ops
    drive(1, 1, 3000, 1000, 1); tick();
    drive(1, 2, 5, 10, 2);      tick();
    drive(1, 3, 17, 0, 3);      tick();
    drive(0, 0, 0, 0, 0);       tick();
    chk("mix_v0", 64'(bus.out_valid), 64'(1));
    chk("mix_add", 64'(bus.out_res), 64'(671));
    tick();
    chk("mix_v1", 64'(bus.out_valid), 64'(1));
    chk("mix_sub", 64'(bus.out_res), 64'(3324));
    tick();
    chk("mix_v2", 64'(bus.out_valid), 64'(1));
    chk("mix_pass", 64'(bus.out_res), 64'(17));
    tick();
    drain();

    // Backpressure fills exactly four stages
    do_reset();
    bus.out_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      drive_rand(1);
      tick();
    end
    chk("bp_accepted", 64'(accepted), 64'(4));
    chk("bp_in_ready", 64'(bus.in_ready), 64'(0));
    chk("bp_out_valid", 64'(bus.out_valid), 64'(1));
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    drain();
    chk("bp_op_count", 64'(bus.op_count), 64'(4));

    // Sticky range error
    chk("re_clear", 64'(bus.range_err), 64'(0));
    drive(1, 0, 3329, 1, 8'h77);
    tick();
    chk("re_set", 64'(bus.range_err), 64'(1));
    for (int i = 0; i < 10; i++) begin
      drive_rand(1);
      tick();
    end
    drain();
    chk("re_sticky", 64'(bus.range_err), 64'(1));

    // Reset with work in flight
    for (int i = 0; i < 3; i++) begin
      drive_rand(1);
      tick();
    end
    do_reset();
    chk("mfr_out_valid", 64'(bus.out_valid), 64'(0));
    chk("mfr_op_count", 64'(bus.op_count), 64'(0));
    chk("mfr_range_err", 64'(bus.range_err), 64'(0));
    for (int i = 0; i < 6; i++) tick();
    chk("mfr_quiet", 64'(bus.out_valid), 64'(0));
    lat_check(0, 1234, 2345, 8'h33, 829);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      drive_rand(($urandom % 4) != 0);
      bus.out_ready = ($urandom % 10) < 7;
      tick();
    end
    drain();
    chk("final_op_count", 64'(bus.op_count), 64'(exp_count));
    chk("final_range_err", 64'(bus.range_err), 64'(exp_range));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
